// File: rtl/display_pkg.sv
// Shared helpers and default constants for the multiplexed display scan path.
package display_pkg;

    localparam int REFRESH_DIV_DEFAULT  = 100000;
    localparam int BLINK_FRAMES_DEFAULT = 64;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Counter/index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-N counter; tick is high during the last count of each period.
module tick_divider
    import display_pkg::*;
#(
    parameter int N = REFRESH_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = idx_width(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count;

    assign tick = (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       count <= '0;
        else if (tick) count <= '0;
        else           count <= count + 1'b1;
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed digit selector: scans NUM_DIGITS digits from one of two sources,
// switching source only at frame boundaries, with per-digit blink and global blank.
module display_scan_mux
    import display_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int DIGIT_W      = 4,
    parameter  int REFRESH_DIV  = REFRESH_DIV_DEFAULT,
    parameter  int BLINK_FRAMES = BLINK_FRAMES_DEFAULT,
    localparam int IDX_W        = idx_width(NUM_DIGITS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] src0,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] src1,
    input  logic                          src_sel,
    input  logic                          blink_en,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    input  logic                          blank,
    output logic [DIGIT_W-1:0]            digit_val,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [IDX_W-1:0]              digit_idx,
    output logic                          frame_start
);

    localparam int BC_W = idx_width(BLINK_FRAMES);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BC_W-1:0]  LAST_BLINK = BC_W'(BLINK_FRAMES - 1);

    logic                          tick;
    logic                          frame_end;
    logic                          active_sel;
    logic                          sel_next;
    logic                          blink_phase;
    logic                          phase_next;
    logic [BC_W-1:0]               blink_cnt;
    logic [BC_W-1:0]               cnt_next;
    logic [IDX_W-1:0]              idx_next;
    logic [NUM_DIGITS*DIGIT_W-1:0] src_word;
    logic [DIGIT_W-1:0]            slice_val;
    logic [NUM_DIGITS-1:0]         an_next;

    tick_divider #(.N(REFRESH_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        frame_end  = tick && (digit_idx == LAST_IDX);
        idx_next   = digit_idx;
        sel_next   = active_sel;
        phase_next = blink_phase;
        cnt_next   = blink_cnt;
        an_next    = '1;

        if (tick) idx_next = (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;

        if (frame_end) begin
            sel_next = src_sel;
            if (blink_cnt == LAST_BLINK) begin
                cnt_next   = '0;
                phase_next = ~blink_phase;
            end else begin
                cnt_next = blink_cnt + 1'b1;
            end
        end

        src_word  = sel_next ? src1 : src0;
        slice_val = src_word[int'(idx_next)*DIGIT_W +: DIGIT_W];

        // Anodes track the post-edge index so blank/blink land with one cycle of latency.
        if (!(blank || (blink_en && blink_mask[idx_next] && phase_next)))
            an_next = ~(NUM_DIGITS'(1) << idx_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_idx   <= LAST_IDX;
            active_sel  <= 1'b0;
            blink_phase <= 1'b0;
            blink_cnt   <= '0;
            digit_val   <= '0;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            digit_idx   <= idx_next;
            active_sel  <= sel_next;
            blink_phase <= phase_next;
            blink_cnt   <= cnt_next;
            an_n        <= an_next;
            frame_start <= frame_end;
            if (tick) digit_val <= slice_val;
        end
    end

endmodule
